// File: rtl/fpu_lzc_norm_pipe.sv
// fpu_lzc_norm_pipe: two-stage leading/trailing-zero counter and normalising shifter.
// Optional exponent-headroom shift clamp is enabled by defining FPU_LZC_MAXSHIFT_EN.
module fpu_lzc_norm_pipe #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_tz,
`ifdef FPU_LZC_MAXSHIFT_EN
  input  logic [CW-1:0]    in_max_shift,
  output logic             out_clamped,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_cnt,
  output logic             out_zero,
  output logic             out_tz
);

  localparam int LVLS = $clog2(WIDTH);

  // Priority tree of 2:1 LZD merges; node j of each level folds children 2j+1 (upper) and 2j.
  function automatic logic [CW-1:0] lzd_tree(input logic [WIDTH-1:0] d);
    logic [CW-1:0] pos [WIDTH];
    logic          val [WIDTH];
    for (int i = 0; i < WIDTH; i++) begin
      pos[i] = '0;
      val[i] = d[i];
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
        pos[j] = val[2*j+1] ? pos[2*j+1] : (pos[2*j] | (CW'(1) << l));
        val[j] = val[2*j+1] | val[2*j];
      end
    end
    return val[0] ? pos[0] : CW'(WIDTH);
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic             s1_tz_q,    s1_tz_d;
  logic [CW-1:0]    s1_cnt_q,   s1_cnt_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_cnt_q,  out_cnt_d;
  logic             out_zero_q, out_zero_d;
  logic             out_tz_q,   out_tz_d;
`ifdef FPU_LZC_MAXSHIFT_EN
  logic [CW-1:0]    s1_max_q,   s1_max_d;
  logic             out_clamped_q, out_clamped_d;
`endif

  logic             s2_adv, s1_adv, in_xfer, s2_load;
  logic [WIDTH-1:0] scan_data;
  logic [CW-1:0]    shamt;
  logic             clamp;

  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && !flush;
    in_xfer  = in_valid && in_ready;
    s2_load  = s1_valid_q && s2_adv && !flush;

    scan_data = in_data;
    if (in_tz) begin
      for (int i = 0; i < WIDTH; i++) scan_data[i] = in_data[WIDTH-1-i];
    end

    shamt = s1_cnt_q;
    clamp = 1'b0;
`ifdef FPU_LZC_MAXSHIFT_EN
    if (s1_cnt_q > s1_max_q) begin
      shamt = s1_max_q;
      clamp = 1'b1;
    end
`endif
  end

  always_comb begin
    s1_valid_d = flush ? 1'b0 : (s1_adv ? in_valid : s1_valid_q);
    s2_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);

    s1_data_d  = s1_data_q;
    s1_tz_d    = s1_tz_q;
    s1_cnt_d   = s1_cnt_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    out_zero_d = out_zero_q;
    out_tz_d   = out_tz_q;
`ifdef FPU_LZC_MAXSHIFT_EN
    s1_max_d      = s1_max_q;
    out_clamped_d = out_clamped_q;
`endif

    if (in_xfer) begin
      s1_data_d = in_data;
      s1_tz_d   = in_tz;
      s1_cnt_d  = lzd_tree(scan_data);
`ifdef FPU_LZC_MAXSHIFT_EN
      s1_max_d  = in_max_shift;
`endif
    end

    // A shift of WIDTH falls off the end entirely, which is what an all-zero input needs.
    if (s2_load) begin
      out_data_d = s1_tz_q ? (s1_data_q >> shamt) : (s1_data_q << shamt);
      out_cnt_d  = shamt;
      out_zero_d = (s1_data_q == '0);
      out_tz_d   = s1_tz_q;
`ifdef FPU_LZC_MAXSHIFT_EN
      out_clamped_d = clamp;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tz_q    <= 1'b0;
      s1_cnt_q   <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
      out_zero_q <= 1'b0;
      out_tz_q   <= 1'b0;
`ifdef FPU_LZC_MAXSHIFT_EN
      s1_max_q      <= '0;
      out_clamped_q <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tz_q    <= s1_tz_d;
      s1_cnt_q   <= s1_cnt_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
      out_zero_q <= out_zero_d;
      out_tz_q   <= out_tz_d;
`ifdef FPU_LZC_MAXSHIFT_EN
      s1_max_q      <= s1_max_d;
      out_clamped_q <= out_clamped_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_zero  = out_zero_q;
  assign out_tz    = out_tz_q;
`ifdef FPU_LZC_MAXSHIFT_EN
  assign out_clamped = out_clamped_q;
`endif

endmodule
